// File: rtl/perceptron_pkg.sv
// Shared constants for the perceptron trainer and the inference classifier:
// default sizes, learning constants and the FSM state encoding.
package perceptron_pkg;

    localparam int          N_FEAT_DEF  = 7;
    localparam int          W_WIDTH_DEF = 8;
    localparam logic [7:0]  W_INIT_DEF  = 8'h80;
    localparam logic [7:0]  B_INIT_DEF  = 8'h00;
    localparam int          THRESH_DEF  = 64;
    localparam logic [7:0]  STEP_DEF    = 8'h10;

    // FSM state encoding kept as plain constants so legacy code can reuse it.
    localparam logic [1:0]  ST_IDLE     = 2'd0;
    localparam logic [1:0]  ST_ACCUM    = 2'd1;
    localparam logic [1:0]  ST_DECIDE   = 2'd2;
    localparam logic [1:0]  ST_UPDATE   = 2'd3;

endpackage

// File: rtl/perceptron_trainer_if.sv
// Sample/result/readback bundle of the perceptron trainer.
interface perceptron_trainer_if
    import perceptron_pkg::*;
#(
    parameter int N_FEAT  = N_FEAT_DEF,
    parameter int W_WIDTH = W_WIDTH_DEF
);
    localparam int IDX_W = $clog2(N_FEAT + 1);

    logic               in_valid;
    logic               in_ready;
    logic [N_FEAT-1:0]  in_feat;
    logic               in_label;
    logic               train_en;
    logic               res_valid;
    logic               res_pred;
    logic               res_err;
    logic [IDX_W-1:0]   rd_idx;
    logic [W_WIDTH-1:0] rd_data;

    modport master (
        output in_valid, in_feat, in_label, train_en, rd_idx,
        input  in_ready, res_valid, res_pred, res_err, rd_data
    );

    modport slave (
        input  in_valid, in_feat, in_label, train_en, rd_idx,
        output in_ready, res_valid, res_pred, res_err, rd_data
    );

endinterface

// File: rtl/perceptron_sat_addsub.sv
// Unsigned saturating add/subtract: clamps to all-ones on overflow and to
// zero on underflow.
module perceptron_sat_addsub #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] y
);
    logic [W:0] wide;

    // One extra bit carries the overflow/borrow that selects the clamp value.
    // NOTE: every output of a combinational block gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        if (sub) begin
            wide = {1'b0, a} - {1'b0, b};
            y    = wide[W] ? '0 : wide[W-1:0];
        end else begin
            wide = {1'b0, a} + {1'b0, b};
            y    = wide[W] ? '1 : wide[W-1:0];
        end
    end

endmodule

// File: rtl/perceptron_trainer.sv
// Perceptron trainer: bit-serial weighted sum over the captured features,
// threshold decision, perceptron-rule update and registered weight readback.
module perceptron_trainer
    import perceptron_pkg::*;
#(
    parameter int                 N_FEAT  = N_FEAT_DEF,
    parameter int                 W_WIDTH = W_WIDTH_DEF,
    parameter logic [W_WIDTH-1:0] W_INIT  = W_INIT_DEF,
    parameter logic [W_WIDTH-1:0] B_INIT  = B_INIT_DEF,
    parameter int                 THRESH  = THRESH_DEF,
    parameter logic [W_WIDTH-1:0] STEP    = STEP_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    perceptron_trainer_if.slave  bus
);
    localparam int IDX_W = $clog2(N_FEAT + 1);

    logic [1:0]         state;
    logic [N_FEAT-1:0]  feat_cap;
    logic               label_cap;
    logic               train_cap;
    logic [IDX_W-1:0]   idx;
    logic [W_WIDTH-1:0] sum;
    logic               pred;
    logic               res_valid_q, res_pred_q, res_err_q;
    logic [W_WIDTH-1:0] rd_data_q;

    logic [W_WIDTH-1:0] w     [N_FEAT];
    logic [W_WIDTH-1:0] w_upd [N_FEAT];
    logic [W_WIDTH-1:0] bias, bias_upd;
    logic [W_WIDTH-1:0] w_sel, sum_next, rd_val;
    logic               feat_bit;
    logic [W_WIDTH+1:0] total;
    logic               do_update;

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.res_valid = res_valid_q;
    assign bus.res_pred  = res_pred_q;
    assign bus.res_err   = res_err_q;
    assign bus.rd_data   = rd_data_q;

    // Wide sum so bias plus a saturated sum can never wrap below the threshold.
    assign total     = {2'b00, sum} + {2'b00, bias};
    assign do_update = (state == ST_UPDATE) && train_cap && (pred != label_cap);

    // One step unit per weight plus the bias; label picks step up or down.
    for (genvar gi = 0; gi < N_FEAT; gi++) begin : g_wstep
        perceptron_sat_addsub #(.W(W_WIDTH)) u_step (
            .a(w[gi]), .b(STEP), .sub(~label_cap), .y(w_upd[gi])
        );
    end

    perceptron_sat_addsub #(.W(W_WIDTH)) u_bias_step (
        .a(bias), .b(STEP), .sub(~label_cap), .y(bias_upd)
    );

    // Shared accumulator adder for the bit-serial scan.
    perceptron_sat_addsub #(.W(W_WIDTH)) u_accum (
        .a(sum), .b(w_sel), .sub(1'b0), .y(sum_next)
    );

    // Select the weight and feature bit addressed by the scan index.
    always_comb begin
        w_sel    = '0;
        feat_bit = 1'b0;
        for (int i = 0; i < N_FEAT; i++) begin
            if (idx == IDX_W'(i)) begin
                w_sel    = w[i];
                feat_bit = feat_cap[i];
            end
        end
    end

    // Readback mux: weights, then bias, anything else reads as zero.
    always_comb begin
        rd_val = '0;
        if (bus.rd_idx == IDX_W'(N_FEAT)) rd_val = bias;
        for (int i = 0; i < N_FEAT; i++) begin
            if (bus.rd_idx == IDX_W'(i)) rd_val = w[i];
        end
    end

    // Control FSM: accept, scan, decide, report.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            feat_cap    <= '0;
            label_cap   <= 1'b0;
            train_cap   <= 1'b0;
            idx         <= '0;
            sum         <= '0;
            pred        <= 1'b0;
            res_valid_q <= 1'b0;
            res_pred_q  <= 1'b0;
            res_err_q   <= 1'b0;
        end else begin
            res_valid_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        feat_cap  <= bus.in_feat;
                        label_cap <= bus.in_label;
                        train_cap <= bus.train_en;
                        idx       <= '0;
                        sum       <= '0;
                        state     <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (feat_bit) sum <= sum_next;
                    idx <= idx + 1'b1;
                    if (idx == IDX_W'(N_FEAT - 1)) state <= ST_DECIDE;
                end
                ST_DECIDE: begin
                    pred  <= (total >= (W_WIDTH + 2)'(THRESH));
                    state <= ST_UPDATE;
                end
                default: begin
                    res_valid_q <= 1'b1;
                    res_pred_q  <= pred;
                    res_err_q   <= pred ^ label_cap;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

    // Weight and bias registers, stepped only on a wrong training prediction.
    // NOTE: this small register array is reset because the trained values must restart from known weights.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_FEAT; i++) w[i] <= W_INIT;
            bias <= B_INIT;
        end else if (do_update) begin
            for (int i = 0; i < N_FEAT; i++) begin
                if (feat_cap[i]) w[i] <= w_upd[i];
            end
            bias <= bias_upd;
        end
    end

    // Registered readback, independent of the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_data_q <= '0;
        else        rd_data_q <= rd_val;
    end

endmodule

// File: tb/tb_perceptron_trainer.sv
// Directed bench for perceptron_trainer: reset readback, inference table,
// saturation, negative/positive training, back-to-back and reset abort.
module tb_perceptron_trainer;
    import perceptron_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    perceptron_trainer_if bus ();

    perceptron_trainer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [6:0] feat;
        logic       label;
        logic       exp_pred;
        logic       exp_err;
    } vec_t;

    vec_t vecs [5];

    // Software copy of the weights for the training sequences.
    logic [7:0] m_w [7];
    logic [7:0] m_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic read_reg(input logic [2:0] idx, output logic [7:0] d);
        @(negedge clk);
        bus.rd_idx = idx;
        @(posedge clk);
        #1;
        d = bus.rd_data;
    endtask

    // Offer one sample, scramble the inputs after the accept edge, and
    // measure edges from accept to the result pulse.
    task automatic run_sample(input logic [6:0] feat, input logic label, input logic train,
                              output logic pred, output logic err, output int lat);
        @(negedge clk);
        bus.in_feat  = feat;
        bus.in_label = label;
        bus.train_en = train;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_feat  = ~feat;
        bus.in_label = ~label;
        bus.train_en = ~train;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (bus.res_valid) begin
                lat = c;
                break;
            end
        end
        pred = bus.res_pred;
        err  = bus.res_err;
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL result_timeout: got no res_valid expected pulse within 20 cycles");
        end
    endtask

    task automatic model_step(input logic [6:0] feat, input logic label, input logic train,
                              output logic pred, output logic err);
        int s;
        s = 0;
        for (int i = 0; i < 7; i++) begin
            if (feat[i]) begin
                s = s + int'(m_w[i]);
                if (s > 255) s = 255;
            end
        end
        pred = ((s + int'(m_b)) >= 64);
        err  = pred ^ label;
        if (train && err) begin
            for (int i = 0; i < 7; i++) begin
                if (feat[i]) m_w[i] = label ? ((m_w[i] > 8'hEF) ? 8'hFF : m_w[i] + 8'h10)
                                            : ((m_w[i] < 8'h10) ? 8'h00 : m_w[i] - 8'h10);
            end
            m_b = label ? ((m_b > 8'hEF) ? 8'hFF : m_b + 8'h10)
                        : ((m_b < 8'h10) ? 8'h00 : m_b - 8'h10);
        end
    endtask

    initial begin
        logic       pred, err, ep, ee;
        logic [7:0] d;
        int         lat, last, pulses;

        vecs[0] = '{7'b0000000, 1'b0, 1'b0, 1'b0};  // sum 0 < 64
        vecs[1] = '{7'b0000001, 1'b0, 1'b1, 1'b1};  // 0x80 >= 64
        vecs[2] = '{7'b1111111, 1'b1, 1'b1, 1'b0};  // saturates at 0xFF
        vecs[3] = '{7'b0000000, 1'b1, 1'b0, 1'b1};  // miss on a positive label
        vecs[4] = '{7'b1000000, 1'b0, 1'b1, 1'b1};  // top feature alone

        bus.in_valid = 1'b0;
        bus.in_feat  = '0;
        bus.in_label = 1'b0;
        bus.train_en = 1'b0;
        bus.rd_idx   = '0;
        rst_n        = 1'b0;
        #12;
        check("reset_in_ready", bus.in_ready, 1);
        check("reset_res_valid", bus.res_valid, 0);
        check("reset_res_pred", bus.res_pred, 0);
        check("reset_res_err", bus.res_err, 0);
        check("reset_rd_data", bus.rd_data, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            read_reg(3'(i), d);
            check($sformatf("reset_read_%0d", i), d, (i < 7) ? 32'h80 : 32'h00);
        end

        // Inference table: no updates, fixed latency.
        for (int i = 0; i < 5; i++) begin
            run_sample(vecs[i].feat, vecs[i].label, 1'b0, pred, err, lat);
            check($sformatf("inf_pred_%0d", i), pred, vecs[i].exp_pred);
            check($sformatf("inf_err_%0d", i), err, vecs[i].exp_err);
            check($sformatf("inf_latency_%0d", i), lat, 9);
            read_reg(3'd0, d);
            check($sformatf("inf_pulse_cleared_%0d", i), bus.res_valid, 0);
            check($sformatf("inf_w0_kept_%0d", i), d, 8'h80);
        end

        for (int i = 0; i < 7; i++) m_w[i] = 8'h80;
        m_b = 8'h00;

        // Negative training on features 0 and 1.
        for (int k = 1; k <= 9; k++) begin
            model_step(7'b0000011, 1'b0, 1'b1, ep, ee);
            run_sample(7'b0000011, 1'b0, 1'b1, pred, err, lat);
            check($sformatf("neg_pred_%0d", k), pred, ep);
            check($sformatf("neg_err_%0d", k), err, ee);
            if (k == 1) begin
                check("neg_first_pred", pred, 1);
                read_reg(3'd0, d); check("neg_first_w0", d, 8'h70);
                read_reg(3'd1, d); check("neg_first_w1", d, 8'h70);
                read_reg(3'd7, d); check("neg_first_bias", d, 8'h00);
            end
        end
        read_reg(3'd0, d); check("neg_final_w0", d, 8'h10);
        read_reg(3'd1, d); check("neg_final_w1", d, 8'h10);
        read_reg(3'd2, d); check("neg_final_w2", d, 8'h80);
        read_reg(3'd7, d); check("neg_final_bias", d, m_b);

        // Positive training with no features: only the bias moves.
        for (int k = 1; k <= 5; k++) begin
            run_sample(7'b0000000, 1'b1, 1'b1, pred, err, lat);
            check($sformatf("pos_pred_%0d", k), pred, (k == 5) ? 1 : 0);
            check($sformatf("pos_err_%0d", k), err, (k == 5) ? 0 : 1);
            read_reg(3'd7, d);
            check($sformatf("pos_bias_%0d", k), d, (k < 4 ? k : 4) * 16);
        end
        read_reg(3'd0, d); check("pos_w0_untouched", d, 8'h10);
        read_reg(3'd3, d); check("pos_w3_untouched", d, 8'h80);

        // Back-to-back: in_valid held high; bias 0x40 alone meets the threshold.
        @(negedge clk);
        bus.in_feat  = 7'b0000000;
        bus.in_label = 1'b0;
        bus.train_en = 1'b0;
        bus.in_valid = 1'b1;
        last   = -1;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (bus.res_valid) begin
                check($sformatf("b2b_ready_with_valid_%0d", pulses), bus.in_ready, 1);
                check($sformatf("b2b_pred_%0d", pulses), bus.res_pred, 1);
                check($sformatf("b2b_err_%0d", pulses), bus.res_err, 1);
                if (last >= 0) check($sformatf("b2b_spacing_%0d", pulses), c - last, 10);
                last = c;
                pulses++;
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("b2b_pulse_count", pulses, 4);
        read_reg(3'd7, d); check("b2b_bias_kept", d, 8'h40);

        // Abort: reset during the feature scan.
        @(negedge clk);
        bus.in_feat  = 7'h7F;
        bus.in_label = 1'b0;
        bus.train_en = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_busy_in_accum", bus.in_ready, 0);
        rst_n = 1'b0;
        #1;
        check("abort_res_valid", bus.res_valid, 0);
        check("abort_in_ready", bus.in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk);
            #1;
            if (bus.res_valid) pulses++;
        end
        check("abort_no_pulse", pulses, 0);
        read_reg(3'd0, d); check("abort_w0", d, 8'h80);
        read_reg(3'd1, d); check("abort_w1", d, 8'h80);
        read_reg(3'd7, d); check("abort_bias", d, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
